// File: rtl/mem_data_path_n.sv
// Multi-channel read front end: per-channel request capture, round-robin grant into an
// address queue, and a single-outstanding memory access FSM returning data per channel.
module mem_data_path_n #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ch_ce,
    input  logic [NUM_CH*ADDR_W-1:0]      ch_addr,
    input  logic [ADDR_W-1:0]             base_addr,
    output logic [NUM_CH*DATA_W-1:0]      ch_data,
    output logic [NUM_CH-1:0]             ch_done,
    output logic [NUM_CH-1:0]             ch_busy,
    output logic                          mem_ce,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_valid,
    input  logic [DATA_W-1:0]             mem_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t               state_q, state_d;
    logic [NUM_CH-1:0]    pend_q;
    logic [ADDR_W-1:0]    pend_addr_q [NUM_CH];
    logic [CH_W-1:0]      rr_ptr_q;
    logic [CH_W-1:0]      fifo_id_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0]    fifo_addr_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CH_W-1:0]      cur_id_q;

    logic                 fifo_full_c, fifo_empty_c;
    logic                 grant_vld_c;
    logic [CH_W-1:0]      grant_id_c;
    logic [CH_W-1:0]      rr_cand_c;
    int unsigned          rr_sum_c;
    logic                 pop_c;
    logic                 capture_c;

    assign fifo_full_c  = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty_c = (fifo_level == '0);
    assign pop_c        = (state_q == IDLE) && !fifo_empty_c;
    assign capture_c    = (state_q == ISSUE) && mem_valid;

    // Round-robin search starting one past the last granted channel
    always_comb begin
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        rr_cand_c   = '0;
        rr_sum_c    = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            rr_sum_c = 32'(rr_ptr_q) + k;
            if (rr_sum_c >= NUM_CH) begin
                rr_sum_c = rr_sum_c - NUM_CH;
            end
            rr_cand_c = CH_W'(rr_sum_c);
            if (!fifo_full_c && !grant_vld_c && pend_q[rr_cand_c]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = rr_cand_c;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty_c) state_d = ISSUE;
            ISSUE:   if (mem_valid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A channel completing this cycle may re-request at the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            ch_busy  <= '0;
            rr_ptr_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                pend_addr_q[i] <= '0;
            end
        end else begin
            if (grant_vld_c) begin
                rr_ptr_q <= (32'(grant_id_c) == NUM_CH - 1) ? '0 : grant_id_c + CH_W'(1);
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (grant_vld_c && (32'(grant_id_c) == i)) begin
                    pend_q[i] <= 1'b0;
                end
                if (ch_ce[i] && (!ch_busy[i] || ch_done[i])) begin
                    pend_q[i]      <= 1'b1;
                    pend_addr_q[i] <= ch_addr[i*ADDR_W +: ADDR_W];
                    ch_busy[i]     <= 1'b1;
                end else if (ch_done[i]) begin
                    ch_busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_level <= '0;
        end else begin
            if (grant_vld_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({grant_vld_c, pop_c})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Queue storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (grant_vld_c) begin
            fifo_id_q[wr_ptr_q]   <= grant_id_c;
            fifo_addr_q[wr_ptr_q] <= pend_addr_q[grant_id_c] + base_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ce   <= 1'b0;
            mem_addr <= '0;
            cur_id_q <= '0;
            ch_done  <= '0;
            ch_data  <= '0;
        end else begin
            mem_ce <= (state_d == ISSUE);
            if (pop_c) begin
                cur_id_q <= fifo_id_q[rd_ptr_q];
                mem_addr <= fifo_addr_q[rd_ptr_q];
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ch_done[i] <= capture_c && (32'(cur_id_q) == i);
                if (capture_c && (32'(cur_id_q) == i)) begin
                    ch_data[i*DATA_W +: DATA_W] <= mem_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_data_path_n.sv
// Directed bench for mem_data_path_n: table of single requests plus hand-written
// sequences for bursts, back-pressure, long memory wait and mid-operation reset.
module tb_mem_data_path_n;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic [NUM_CH-1:0]        ch_ce;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [ADDR_W-1:0]        base_addr;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_done, ch_busy;
    logic                     mem_ce, mem_valid;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_data;
    logic [3:0]               fifo_level;

    // Two-entry queue instance
    logic [NUM_CH-1:0]        d2_ch_ce;
    logic [NUM_CH*ADDR_W-1:0] d2_ch_addr;
    logic [ADDR_W-1:0]        d2_base_addr;
    logic [NUM_CH*DATA_W-1:0] d2_ch_data;
    logic [NUM_CH-1:0]        d2_ch_done, d2_ch_busy;
    logic                     d2_mem_ce, d2_mem_valid;
    logic [ADDR_W-1:0]        d2_mem_addr;
    logic [DATA_W-1:0]        d2_mem_data;
    logic [1:0]               d2_fifo_level;

    assign mem_data    = {24'd0, mem_addr};
    assign d2_mem_data = {24'd0, d2_mem_addr};

    mem_data_path_n #(.NUM_CH(4), .ADDR_W(8), .DATA_W(32), .FIFO_DEPTH(8)) u_dut (
        .clk(clk), .rst(rst), .ch_ce(ch_ce), .ch_addr(ch_addr), .base_addr(base_addr),
        .ch_data(ch_data), .ch_done(ch_done), .ch_busy(ch_busy), .mem_ce(mem_ce),
        .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data), .fifo_level(fifo_level)
    );

    mem_data_path_n #(.NUM_CH(4), .ADDR_W(8), .DATA_W(32), .FIFO_DEPTH(2)) u_dut_d2 (
        .clk(clk), .rst(rst), .ch_ce(d2_ch_ce), .ch_addr(d2_ch_addr), .base_addr(d2_base_addr),
        .ch_data(d2_ch_data), .ch_done(d2_ch_done), .ch_busy(d2_ch_busy), .mem_ce(d2_mem_ce),
        .mem_addr(d2_mem_addr), .mem_valid(d2_mem_valid), .mem_data(d2_mem_data),
        .fifo_level(d2_fifo_level)
    );

    typedef struct {
        int          ch;
        logic [7:0]  addr;
        logic [7:0]  base;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [7];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_data    [4];
    logic [31:0] d2_exp_data [4];

    function automatic logic [127:0] pack(input logic [31:0] d [4]);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = d[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         edges;
        logic       seen_ce, done_seen;
        logic [7:0] got_addr;
        logic [3:0] exp_done;
        exp_done = 4'(1 << v.ch);
        @(negedge clk);
        ch_ce = exp_done;
        ch_addr[v.ch*8 +: 8] = v.addr;
        base_addr = v.base;
        mem_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ch_ce = '0;
        chk("vec_busy_set", 128'(ch_busy), 128'(exp_done));
        edges = 0; seen_ce = 1'b0; done_seen = 1'b0; got_addr = '0;
        while (!done_seen && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (mem_ce && !seen_ce) begin
                seen_ce  = 1'b1;
                got_addr = mem_addr;
            end
            if (ch_done != '0) done_seen = 1'b1;
        end
        chk("vec_latency", 128'(edges), 128'(3));
        chk("vec_mem_addr", 128'(got_addr), 128'(v.exp[7:0]));
        chk("vec_done", 128'(ch_done), 128'(exp_done));
        exp_data[v.ch] = v.exp;
        chk("vec_data", ch_data, pack(exp_data));
        @(negedge clk);
        chk("vec_done_clear", 128'(ch_done), 128'(0));
        chk("vec_busy_clear", 128'(ch_busy), 128'(0));
    endtask

    // All four channels strobe together; completions must follow round-robin from start
    task automatic burst(input int start, input logic [7:0] base);
        int         n, exp_id, extra;
        logic [3:0] exp_done;
        @(negedge clk);
        ch_ce = 4'hF;
        for (int c = 0; c < 4; c++) ch_addr[c*8 +: 8] = 8'h40 + 8'(c);
        base_addr = base;
        mem_valid = 1'b1;
        @(negedge clk);
        ch_ce = '0;
        n = 0;
        for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
            @(negedge clk);
            if (ch_done != '0) begin
                exp_id   = (start + n) % 4;
                exp_done = 4'(1 << exp_id);
                chk("burst_order", 128'(ch_done), 128'(exp_done));
                exp_data[exp_id] = 32'h40 + 32'(exp_id) + 32'(base);
                chk("burst_data", ch_data, pack(exp_data));
                n++;
            end
        end
        chk("burst_count", 128'(n), 128'(4));
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (ch_done != '0) extra++;
        end
        chk("burst_extra_done", 128'(extra), 128'(0));
        chk("burst_busy_clear", 128'(ch_busy), 128'(0));
    endtask

    initial begin
        int         n, extra, exp_id;
        logic       ok, any_ce;
        logic [3:0] exp_done;

        vecs[0] = '{2, 8'h10, 8'h05, 32'h15};
        vecs[1] = '{0, 8'h3C, 8'h01, 32'h3D};
        vecs[2] = '{1, 8'h80, 8'h22, 32'hA2};
        vecs[3] = '{1, 8'hFF, 8'h01, 32'h00};
        vecs[4] = '{2, 8'hAA, 8'h00, 32'hAA};
        vecs[5] = '{0, 8'hC3, 8'h3D, 32'h00};
        vecs[6] = '{3, 8'h7F, 8'h80, 32'hFF};

        rst = 1'b1;
        ch_ce = '0; ch_addr = '0; base_addr = '0; mem_valid = 1'b0;
        d2_ch_ce = '0; d2_ch_addr = '0; d2_base_addr = '0; d2_mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = '0;
            d2_exp_data[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("reset_ch_data", ch_data, 128'(0));
        chk("reset_ch_done", 128'(ch_done), 128'(0));
        chk("reset_ch_busy", 128'(ch_busy), 128'(0));
        chk("reset_mem_ce", 128'(mem_ce), 128'(0));
        chk("reset_mem_addr", 128'(mem_addr), 128'(0));
        chk("reset_fifo_level", 128'(fifo_level), 128'(0));
        chk("reset_d2_level", 128'(d2_fifo_level), 128'(0));
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Last table grant was channel 3, so both bursts start at 0
        burst(0, 8'h03);
        burst(0, 8'h10);
        run_vec('{1, 8'h20, 8'h00, 32'h20});
        burst(2, 8'h07);

        // Long memory wait on channel 1 with an ignored re-strobe while busy
        @(negedge clk);
        mem_valid = 1'b0;
        ch_ce = 4'b0010;
        ch_addr[15:8] = 8'h55;
        base_addr = 8'h01;
        @(negedge clk);
        ch_ce = '0;
        ok = 1'b0;
        for (int cyc = 0; cyc < 10 && !ok; cyc++) begin
            @(negedge clk);
            ok = mem_ce;
        end
        chk("hold_issue_seen", 128'(ok), 128'(1));
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                ch_ce = 4'b0010;
                ch_addr[15:8] = 8'h99;
            end else begin
                ch_ce = '0;
            end
            @(negedge clk);
            chk("hold_mem_ce", 128'(mem_ce), 128'(1));
            chk("hold_mem_addr", 128'(mem_addr), 128'(8'h56));
            chk("hold_no_done", 128'(ch_done), 128'(0));
        end
        ch_ce = '0;
        chk("hold_busy", 128'(ch_busy), 128'(4'b0010));
        mem_valid = 1'b1;
        @(negedge clk);
        chk("hold_done", 128'(ch_done), 128'(4'b0010));
        exp_data[1] = 32'h56;
        chk("hold_data", ch_data, pack(exp_data));
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (ch_done != '0) extra++;
        end
        chk("hold_single_done", 128'(extra), 128'(0));
        chk("hold_busy_clear", 128'(ch_busy), 128'(0));

        // Two-entry queue: back-pressure holds one channel pending without loss
        @(negedge clk);
        d2_mem_valid = 1'b0;
        d2_ch_ce = 4'hF;
        for (int c = 0; c < 4; c++) d2_ch_addr[c*8 +: 8] = 8'h60 + 8'(c);
        @(negedge clk);
        d2_ch_ce = '0;
        repeat (8) @(negedge clk);
        chk("d2_level_full", 128'(d2_fifo_level), 128'(2));
        chk("d2_busy_all", 128'(d2_ch_busy), 128'(4'hF));
        chk("d2_mem_ce", 128'(d2_mem_ce), 128'(1));
        repeat (4) @(negedge clk);
        chk("d2_level_held", 128'(d2_fifo_level), 128'(2));
        chk("d2_no_done", 128'(d2_ch_done), 128'(0));
        d2_mem_valid = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            @(negedge clk);
            if (d2_ch_done != '0) begin
                exp_id   = n;
                exp_done = 4'(1 << exp_id);
                chk("d2_order", 128'(d2_ch_done), 128'(exp_done));
                d2_exp_data[exp_id] = 32'h60 + 32'(exp_id);
                chk("d2_data", d2_ch_data, pack(d2_exp_data));
                n++;
            end
        end
        chk("d2_count", 128'(n), 128'(4));
        repeat (4) @(negedge clk);
        chk("d2_level_empty", 128'(d2_fifo_level), 128'(0));
        chk("d2_busy_clear", 128'(d2_ch_busy), 128'(0));

        // Reset while in ISSUE with two entries queued
        @(negedge clk);
        mem_valid = 1'b0;
        ch_ce = 4'b0111;
        @(negedge clk);
        ch_ce = '0;
        ok = 1'b0;
        for (int cyc = 0; cyc < 20 && !ok; cyc++) begin
            @(negedge clk);
            ok = mem_ce && (fifo_level == 4'd2);
        end
        chk("rst_setup", 128'(ok), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_ch_data", ch_data, 128'(0));
        chk("rst_ch_done", 128'(ch_done), 128'(0));
        chk("rst_ch_busy", 128'(ch_busy), 128'(0));
        chk("rst_mem_ce", 128'(mem_ce), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_fifo_level", 128'(fifo_level), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        mem_valid = 1'b1;
        extra = 0;
        any_ce = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ch_done != '0) extra++;
            if (mem_ce) any_ce = 1'b1;
        end
        chk("rst_no_done", 128'(extra), 128'(0));
        chk("rst_no_mem_ce", 128'(any_ce), 128'(0));
        chk("rst_level_stays0", 128'(fifo_level), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
